vga_sync_timing: RTL

- Produces the pixel coordinate stream (o_px, o_py) consumed by the pattern generators, and the VGA sync/blanking signals.
- Takes the pattern's RGB output back, blanks it outside the active area, and delays the syncs so they match the pattern's register latency.
- Sits between the pattern generators and the board's VGA pins.
- Default timing is 640x480@60 with a 25 MHz pixel clock.

---
 rtl/vga_sync_timing_pkg.sv | 48 ++++
 rtl/vga_sync_timing_if.sv | 24 ++
 rtl/vga_sync_timing_delay_line.sv | 37 +++
 rtl/vga_sync_timing.sv | 130 +++++++++++++
 4 files changed

// File: rtl/vga_sync_timing_pkg.sv
// Shared constants and types for the VGA timing slice.
// Default numbers describe 640x480@60 with a 25 MHz pixel clock.
package vga_timing_pkg;

    // Counter and colour widths
    localparam int CNT_W     = 10;
    localparam int COLOR_W   = 3;
    localparam int MAX_TOTAL = 1 << CNT_W;

    // 640x480@60 horizontal timing, in pixel clocks
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

    // 640x480@60 vertical timing, in lines
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    // Both syncs are active low on the VGA connector
    localparam logic SYNC_ACTIVE_LEVEL = 1'b0;

    // Signals that travel together through the pattern-latency delay line
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
    } sync_bundle_t;

    // Idle bundle: syncs deasserted, outside the visible area
    localparam sync_bundle_t BUNDLE_IDLE = '{
        hsync:  ~SYNC_ACTIVE_LEVEL,
        vsync:  ~SYNC_ACTIVE_LEVEL,
        active: 1'b0
    };

    // A total fits when the CNT_W-bit counter can reach total-1
    function automatic bit total_fits(input int total);
        return (total > 0) && (total <= MAX_TOTAL);
    endfunction

    localparam bit DEFAULT_TIMING_OK = total_fits(DEF_H_TOTAL) && total_fits(DEF_V_TOTAL);

endpackage

// File: rtl/vga_sync_timing_if.sv
// Pattern-side bus: coordinates out to the pattern generator, RGB back in.
interface vga_sync_timing_if
    import vga_timing_pkg::*;
;
    logic [CNT_W-1:0]   o_px;
    logic [CNT_W-1:0]   o_py;
    logic               o_active;
    logic               o_frame_start;
    logic [COLOR_W-1:0] i_red;
    logic [COLOR_W-1:0] i_green;
    logic [COLOR_W-1:0] i_blue;

    // Timing generator side
    modport master (
        output o_px, o_py, o_active, o_frame_start,
        input  i_red, i_green, i_blue
    );

    // Pattern generator side
    modport slave (
        input  o_px, o_py, o_active, o_frame_start,
        output i_red, i_green, i_blue
    );
endinterface

// File: rtl/vga_sync_timing_delay_line.sv
// Fixed-depth shift register with synchronous reset; depth 0 is a plain wire.
module vga_delay_line #(
    parameter int               WIDTH       = 1,
    parameter int               DEPTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = &{1'b0, i_clk, i_reset};
        assign o_data = i_data;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage_reg [DEPTH];

        // Shift one stage per clock; reset flushes every stage to the idle value
        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_reg[i] <= RESET_VALUE;
                end
            end else begin
                stage_reg[0] <= i_data;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_reg[i] <= stage_reg[i-1];
                end
            end
        end

        assign o_data = stage_reg[DEPTH-1];
    end

endmodule

// File: rtl/vga_sync_timing.sv
// Raster counters, sync decode and pin stage for the VGA output.
// Coordinates go to the pattern generator; its RGB comes back PATTERN_LATENCY
// clocks later and is blanked against a matching delayed copy of active/sync.
module vga_sync_timing
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE        = DEF_H_ACTIVE,
    parameter int H_FRONT         = DEF_H_FRONT,
    parameter int H_SYNC          = DEF_H_SYNC,
    parameter int H_BACK          = DEF_H_BACK,
    parameter int V_ACTIVE        = DEF_V_ACTIVE,
    parameter int V_FRONT         = DEF_V_FRONT,
    parameter int V_SYNC          = DEF_V_SYNC,
    parameter int V_BACK          = DEF_V_BACK,
    parameter int PATTERN_LATENCY = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    vga_sync_timing_if.master    pat,
    output logic                 o_vga_hsync,
    output logic                 o_vga_vsync,
    output logic [COLOR_W-1:0]   o_vga_red,
    output logic [COLOR_W-1:0]   o_vga_green,
    output logic [COLOR_W-1:0]   o_vga_blue
);

    localparam int H_TOTAL      = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_ACTIVE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    if (!total_fits(H_TOTAL) || !total_fits(V_TOTAL) ||
        PATTERN_LATENCY < 0 || PATTERN_LATENCY > 7) begin : g_bad_params
        $error("vga_sync_timing: totals must be 1..1024 and PATTERN_LATENCY 0..7");
    end

    logic [CNT_W-1:0]   h_cnt_reg, v_cnt_reg;
    logic [CNT_W-1:0]   h_next, v_next;
    logic               running_reg;
    logic               active_reg;
    logic               frame_start_reg;
    sync_bundle_t       raw_bundle;
    sync_bundle_t       dly_bundle;
    logic               hsync_pin_reg, vsync_pin_reg;
    logic [COLOR_W-1:0] red_pin_reg, green_pin_reg, blue_pin_reg;

    // Next raster position; the first clock out of reset holds (0,0) so it is presented as a frame start
    always_comb begin
        h_next = '0;
        v_next = '0;
        if (running_reg) begin
            if (h_cnt_reg == H_LAST) begin
                h_next = '0;
                v_next = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
            end else begin
                h_next = h_cnt_reg + 1'b1;
                v_next = v_cnt_reg;
            end
        end
    end

    // Counters plus active/frame-start flags registered together so they stay aligned
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            h_cnt_reg       <= '0;
            v_cnt_reg       <= '0;
            running_reg     <= 1'b0;
            active_reg      <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            h_cnt_reg       <= h_next;
            v_cnt_reg       <= v_next;
            running_reg     <= 1'b1;
            active_reg      <= (int'(h_next) < H_ACTIVE) && (int'(v_next) < V_ACTIVE);
            frame_start_reg <= (h_next == '0) && (v_next == '0);
        end
    end

    assign pat.o_px          = h_cnt_reg;
    assign pat.o_py          = v_cnt_reg;
    assign pat.o_active      = active_reg;
    assign pat.o_frame_start = frame_start_reg;

    // Sync decode aligned with the registered coordinates
    assign raw_bundle.hsync  = ((int'(h_cnt_reg) >= H_SYNC_START) && (int'(h_cnt_reg) < H_SYNC_END))
                               ? SYNC_ACTIVE_LEVEL : ~SYNC_ACTIVE_LEVEL;
    assign raw_bundle.vsync  = ((int'(v_cnt_reg) >= V_SYNC_START) && (int'(v_cnt_reg) < V_SYNC_END))
                               ? SYNC_ACTIVE_LEVEL : ~SYNC_ACTIVE_LEVEL;
    assign raw_bundle.active = active_reg;

    vga_delay_line #(
        .WIDTH       ($bits(sync_bundle_t)),
        .DEPTH       (PATTERN_LATENCY),
        .RESET_VALUE (BUNDLE_IDLE)
    ) u_sync_delay (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_data  (raw_bundle),
        .o_data  (dly_bundle)
    );

    // Pin stage: blank colour outside the delayed active area, forward delayed syncs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            hsync_pin_reg <= ~SYNC_ACTIVE_LEVEL;
            vsync_pin_reg <= ~SYNC_ACTIVE_LEVEL;
            red_pin_reg   <= '0;
            green_pin_reg <= '0;
            blue_pin_reg  <= '0;
        end else begin
            hsync_pin_reg <= dly_bundle.hsync;
            vsync_pin_reg <= dly_bundle.vsync;
            red_pin_reg   <= dly_bundle.active ? pat.i_red   : '0;
            green_pin_reg <= dly_bundle.active ? pat.i_green : '0;
            blue_pin_reg  <= dly_bundle.active ? pat.i_blue  : '0;
        end
    end

    assign o_vga_hsync = hsync_pin_reg;
    assign o_vga_vsync = vsync_pin_reg;
    assign o_vga_red   = red_pin_reg;
    assign o_vga_green = green_pin_reg;
    assign o_vga_blue  = blue_pin_reg;

endmodule
